// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the RAM built-in self-test.
package ram_bist_pkg;

  // March controller states, in the order they are visited.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M0_W  = 3'd1,
    S_M1_RW = 3'd2,
    S_M2_RW = 3'd3,
    S_M3_R  = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Four march elements: M0 up (w P), M1 up (r P, w ~P), M2 down (r ~P, w P), M3 up (r P).
  localparam int unsigned NUM_ELEM = 4;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [31:0] DEF_PATTERN = 32'hA5A55A5A;

  localparam int unsigned ERR_W = 8;

  // Only M2 walks the address space downwards.
  function automatic logic elem_dir(input state_t s);
    return (s == S_M2_RW) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: RAM-side bus driven by the BIST (master) and served by the RAM (slave).
interface ram_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              ena;
  logic              wena;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output ena, output wena, output addr, output din, input dout);
  modport slave  (input ena, input wena, input addr, input din, output dout);
endinterface

// File: rtl/ram_bist_chk.sv
// ram_bist_chk: read-data comparator with first-fail latch and saturating error count.
module ram_bist_chk
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_stb,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_act,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_mismatch,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [ERR_W-1:0]  o_err_cnt
);

  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [ERR_W-1:0]  r_err_cnt;

  assign o_mismatch  = i_stb && (i_exp != i_act);
  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_err_cnt   = r_err_cnt;

  // Result registers: cleared on a new run, updated on the edge after a mismatching compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_err_cnt   <= '0;
    end else if (i_clr) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_err_cnt   <= '0;
    end else if (o_mismatch) begin
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= i_addr;
      end
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist: march BIST master for the single-port RAM.
// Optional feature macro: RAM_BIST_STOP_ON_FAIL_EN (abort to DONE on the first mismatch).
//
// state   | meaning
// IDLE    | waiting for start, RAM port quiet
// M0_W    | ascending, write P
// M1_RW   | ascending, read (expect P) then write ~P, 2 cycles/address
// M2_RW   | descending, read (expect ~P) then write P, 2 cycles/address
// M3_R    | ascending, one read per cycle, compared a cycle later
// FLUSH   | compare of the last M3 read
// DONE    | results held, start restarts
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  ram_bist_if.master        ram,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [ERR_W-1:0]  o_err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_MIN = '0;

  state_t            r_state, w_state_pre, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_step;
  logic              r_phase, w_phase_nxt;
  logic              r_rd_vld, w_rd_vld_nxt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              w_at_tc;

  logic              w_ena, w_wena;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_cmp_stb, w_clr;
  logic [DATA_W-1:0] w_cmp_exp;
  logic [ADDR_W-1:0] w_cmp_addr;
  logic              w_mismatch;

  assign w_addr_step = (elem_dir(r_state) == DIR_DN) ? r_addr - 1'b1 : r_addr + 1'b1;
  assign w_at_tc     = (elem_dir(r_state) == DIR_DN) ? (r_addr == ADDR_MIN) : (r_addr == ADDR_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Address counter, read/write phase and M3 read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_phase   <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_phase   <= w_phase_nxt;
      r_rd_vld  <= w_rd_vld_nxt;
      r_rd_addr <= r_addr;
    end
  end

  // Next state, RAM port drive and compare requests.
  always_comb begin
    w_state_pre  = r_state;
    w_addr_nxt   = r_addr;
    w_phase_nxt  = r_phase;
    w_rd_vld_nxt = 1'b0;
    w_ena        = 1'b0;
    w_wena       = 1'b0;
    w_addr       = '0;
    w_din        = '0;
    w_cmp_stb    = 1'b0;
    w_cmp_exp    = '0;
    w_cmp_addr   = '0;
    w_clr        = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        o_done = (r_state == S_DONE);
        if (i_start) begin
          w_state_pre = S_M0_W;
          w_addr_nxt  = '0;
          w_phase_nxt = 1'b0;
          w_clr       = 1'b1;
        end
      end
      S_M0_W: begin
        o_busy = 1'b1;
        w_ena  = 1'b1;
        w_wena = 1'b1;
        w_addr = r_addr;
        w_din  = PATTERN;
        if (w_at_tc) begin
          w_state_pre = S_M1_RW;
          w_addr_nxt  = ADDR_MIN;
        end else begin
          w_addr_nxt = w_addr_step;
        end
      end
      S_M1_RW, S_M2_RW: begin
        o_busy = 1'b1;
        w_ena  = 1'b1;
        w_addr = r_addr;
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          // Read data for this address is on ram.dout now; overwrite it in the same cycle.
          w_wena      = 1'b1;
          w_din       = (r_state == S_M1_RW) ? ~PATTERN : PATTERN;
          w_cmp_stb   = 1'b1;
          w_cmp_exp   = (r_state == S_M1_RW) ? PATTERN : ~PATTERN;
          w_cmp_addr  = r_addr;
          w_phase_nxt = 1'b0;
          if (w_at_tc) begin
            w_state_pre = (r_state == S_M1_RW) ? S_M2_RW : S_M3_R;
            w_addr_nxt  = (r_state == S_M1_RW) ? ADDR_MAX : ADDR_MIN;
          end else begin
            w_addr_nxt = w_addr_step;
          end
        end
      end
      S_M3_R: begin
        o_busy       = 1'b1;
        w_ena        = 1'b1;
        w_addr       = r_addr;
        w_rd_vld_nxt = 1'b1;
        w_cmp_stb    = r_rd_vld;
        w_cmp_exp    = PATTERN;
        w_cmp_addr   = r_rd_addr;
        if (w_at_tc) w_state_pre = S_FLUSH;
        else         w_addr_nxt  = w_addr_step;
      end
      S_FLUSH: begin
        o_busy      = 1'b1;
        w_cmp_stb   = r_rd_vld;
        w_cmp_exp   = PATTERN;
        w_cmp_addr  = r_rd_addr;
        w_state_pre = S_DONE;
      end
      default: w_state_pre = S_IDLE;
    endcase
  end

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign w_state_nxt = w_mismatch ? S_DONE : w_state_pre;
`else
  logic w_unused_mismatch;
  assign w_unused_mismatch = w_mismatch;
  assign w_state_nxt       = w_state_pre;
`endif

  assign ram.ena  = w_ena;
  assign ram.wena = w_wena;
  assign ram.addr = w_addr;
  assign ram.din  = w_din;

  ram_bist_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_stb       (w_cmp_stb),
    .i_exp       (w_cmp_exp),
    .i_act       (ram.dout),
    .i_addr      (w_cmp_addr),
    .o_mismatch  (w_mismatch),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_err_cnt   (o_err_cnt)
  );

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed bench for ram_bist with a behavioural RAM and an optional stuck-at fault.
module tb_ram_bist;
  import ram_bist_pkg::*;

  localparam int          AW = 5;
  localparam int          DW = 32;
  localparam logic [31:0] P  = 32'hA5A55A5A;
  localparam logic [31:0] NP = 32'h5A5AA5A5;
  localparam int          NC = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_cnt;
  logic          fault_en = 1'b0;
  logic [31:0]   mem [0:31];

  int tests = 0;
  int fails = 0;

  logic        tr_busy [0:NC-1];
  logic        tr_ena  [0:NC-1];
  logic        tr_wena [0:NC-1];
  logic [4:0]  tr_addr [0:NC-1];
  logic [31:0] tr_din  [0:NC-1];
  int          done_cyc;
  logic        fail0;
  logic [7:0]  err0;

  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_bist #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .ram         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_err_cnt   (err_cnt)
  );

  // Synchronous RAM, one-cycle read latency; addr 21 bit 0 optionally stuck at 1.
  always @(posedge clk) begin
    if (bus.ena) begin
      if (bus.wena) mem[bus.addr] <= bus.din;
      else bus.dout <= mem[bus.addr] | ((fault_en && bus.addr == 5'd21) ? 32'd1 : 32'd0);
    end
  end

  task automatic run_trace(input bit inject);
    @(negedge clk);
    start = 1'b1;
    done_cyc = -1;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      start = inject && (c == 10 || c == 150);
      tr_busy[c] = busy;
      tr_ena[c]  = bus.ena;
      tr_wena[c] = bus.wena;
      tr_addr[c] = bus.addr;
      tr_din[c]  = bus.din;
      if (c == 0) begin
        fail0 = fail;
        err0  = err_cnt;
      end
      if (done && done_cyc < 0) done_cyc = c;
    end
    start = 1'b0;
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int c = 0; c < NC; c++) if (tr_busy[c]) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, fail} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got busy/done/fail=%b%b%b want 000", busy, done, fail);
    end
    tests++;
    if (fail_addr !== 5'd0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_results got fail_addr=%0d err_cnt=%0d want 0 0", fail_addr, err_cnt);
    end
    tests++;
    if (bus.ena !== 1'b0 || bus.wena !== 1'b0 || bus.addr !== 5'd0 || bus.din !== 32'd0) begin
      fails++; $display("FAIL reset_ram_port got ena=%b wena=%b addr=%0d din=%h want all 0", bus.ena, bus.wena, bus.addr, bus.din);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pass();
    fault_en = 1'b0;
    run_trace(1'b0);
    tests++;
    if (done_cyc != 193) begin fails++; $display("FAIL pass_done_cycle got %0d want 193", done_cyc); end
    tests++;
    if (busy_count() != 193) begin fails++; $display("FAIL pass_busy_count got %0d want 193", busy_count()); end
    tests++;
    if (tr_busy[0] !== 1'b1 || tr_busy[192] !== 1'b1 || tr_busy[193] !== 1'b0) begin
      fails++; $display("FAIL pass_busy_edges got c0=%b c192=%b c193=%b want 1 1 0", tr_busy[0], tr_busy[192], tr_busy[193]);
    end
    tests++;
    if (fail !== 1'b0 || err_cnt !== 8'd0 || fail_addr !== 5'd0) begin
      fails++; $display("FAIL pass_result got fail=%b err_cnt=%0d fail_addr=%0d want 0 0 0", fail, err_cnt, fail_addr);
    end
  endtask

  task automatic test_trace();
    int bad = 0;
    for (int c = 0; c < 32; c++)
      if (tr_ena[c] !== 1'b1 || tr_wena[c] !== 1'b1 || tr_addr[c] !== 5'(c) || tr_din[c] !== P) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL m0_trace got %0d bad cycles want 0", bad); end
    tests++;
    if (tr_ena[32] !== 1'b1 || tr_wena[32] !== 1'b0 || tr_addr[32] !== 5'd0 ||
        tr_wena[33] !== 1'b1 || tr_addr[33] !== 5'd0 || tr_din[33] !== NP) begin
      fails++; $display("FAIL m1_first got wena=%b/%b addr=%0d/%0d din=%h want 0/1 0/0 %h",
                        tr_wena[32], tr_wena[33], tr_addr[32], tr_addr[33], tr_din[33], NP);
    end
    tests++;
    if (tr_ena[96] !== 1'b1 || tr_wena[96] !== 1'b0 || tr_addr[96] !== 5'd31 ||
        tr_ena[97] !== 1'b1 || tr_wena[97] !== 1'b1 || tr_addr[97] !== 5'd31 || tr_din[97] !== P) begin
      fails++; $display("FAIL m2_first got wena=%b/%b addr=%0d/%0d din=%h want 0/1 31/31 %h",
                        tr_wena[96], tr_wena[97], tr_addr[96], tr_addr[97], tr_din[97], P);
    end
    tests++;
    if (tr_ena[160] !== 1'b1 || tr_wena[160] !== 1'b0 || tr_addr[160] !== 5'd0 ||
        tr_ena[191] !== 1'b1 || tr_addr[191] !== 5'd31 || tr_ena[192] !== 1'b0) begin
      fails++; $display("FAIL m3_trace got ena160=%b addr160=%0d addr191=%0d ena192=%b want 1 0 31 0",
                        tr_ena[160], tr_addr[160], tr_addr[191], tr_ena[192]);
    end
    bad = 0;
    for (int c = 193; c < NC; c++) if (tr_ena[c] !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL done_ena got %0d active cycles want 0", bad); end
  endtask

  task automatic test_ignore_start();
    run_trace(1'b1);
    tests++;
    if (done_cyc != 193 || busy_count() != 193) begin
      fails++; $display("FAIL ignore_start got done_cyc=%0d busy=%0d want 193 193", done_cyc, busy_count());
    end
  endtask

  task automatic test_fault();
    int late = 0;
    fault_en = 1'b1;
    run_trace(1'b0);
    fault_en = 1'b0;
    for (int c = 76; c < NC; c++) if (tr_ena[c] !== 1'b0) late++;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    tests++;
    if (done_cyc != 76) begin fails++; $display("FAIL fault_done_cycle got %0d want 76", done_cyc); end
    tests++;
    if (fail !== 1'b1 || fail_addr !== 5'd21 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL fault_result got fail=%b fail_addr=%0d err_cnt=%0d want 1 21 1", fail, fail_addr, err_cnt);
    end
    tests++;
    if (late != 0 || tr_ena[75] !== 1'b1) begin
      fails++; $display("FAIL fault_stop_ena got late=%0d ena75=%b want 0 1", late, tr_ena[75]);
    end
`else
    tests++;
    if (done_cyc != 193) begin fails++; $display("FAIL fault_done_cycle got %0d want 193", done_cyc); end
    tests++;
    if (fail !== 1'b1 || fail_addr !== 5'd21 || err_cnt !== 8'd2) begin
      fails++; $display("FAIL fault_result got fail=%b fail_addr=%0d err_cnt=%0d want 1 21 2", fail, fail_addr, err_cnt);
    end
    tests++;
    if (late == 0) begin fails++; $display("FAIL fault_full_run got %0d active cycles after 75 want >0", late); end
`endif
  endtask

  task automatic test_back_to_back();
    run_trace(1'b0);
    tests++;
    if (fail0 !== 1'b0 || err0 !== 8'd0) begin
      fails++; $display("FAIL restart_clear got fail=%b err_cnt=%0d at cycle 0 want 0 0", fail0, err0);
    end
    tests++;
    if (done_cyc != 193 || fail !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL restart_pass got done_cyc=%0d fail=%b err_cnt=%0d want 193 0 0", done_cyc, fail, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, fail, bus.ena, bus.wena} !== 5'b0 || fail_addr !== 5'd0 || err_cnt !== 8'd0 ||
        bus.addr !== 5'd0 || bus.din !== 32'd0) begin
      fails++; $display("FAIL mid_reset_outputs got busy=%b done=%b fail=%b ena=%b err_cnt=%0d want all 0",
                        busy, done, fail, bus.ena, err_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_trace(1'b0);
    tests++;
    if (done_cyc != 193 || fail !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL mid_reset_rerun got done_cyc=%0d fail=%b err_cnt=%0d want 193 0 0", done_cyc, fail, err_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    bus.dout = 32'd0;
    test_reset();
    test_pass();
    test_trace();
    test_ignore_start();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
